mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 48 ++++
 rtl/mem_port_arbiter_rr_pick3.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the unified instruction/data memory port arbiter.
//   - Requester identifiers (LSU, instruction fetch, result-dump engine).
//   - Arbiter FSM state encoding.
//   - Default address/data widths and the statistics counter width.
//   - Small helpers for converting between requester ids and one-hot grants.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int NREQ_DEF   = 3;
    localparam int STAT_W     = 16;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_LSU   = 2'd0;
    localparam req_id_t REQ_FETCH = 2'd1;
    localparam req_id_t REQ_DUMP  = 2'd2;

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Requester that follows id in round-robin order (wraps 2 -> 0).
    function automatic req_id_t rr_next(input req_id_t id);
        return (id == REQ_DUMP) ? REQ_LSU : req_id_t'(id + 2'd1);
    endfunction

    // Encode a one-hot grant as a requester id; an all-zero vector maps to
    // REQ_LSU, so callers qualify the result with |oh.
    function automatic req_id_t onehot_to_id(input logic [2:0] oh);
        if (oh[2])      return REQ_DUMP;
        else if (oh[1]) return REQ_FETCH;
        else            return REQ_LSU;
    endfunction

    function automatic logic [2:0] id_to_onehot(input req_id_t id);
        case (id)
            REQ_FETCH: return 3'b010;
            REQ_DUMP:  return 3'b100;
            default:   return 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick3.sv
// -----------------------------------------------------------------------------
// rr_pick3
// Combinational 3-way round-robin picker. Among the requesters that are both
// valid and unmasked, grants the first one found searching upward from ptr_i,
// wrapping modulo 3. At most one grant bit is set.
// Ports:
//   valid_i [2:0]  request valid per requester
//   ptr_i   [1:0]  highest-priority requester this cycle (0..2)
//   mask_i  [2:0]  eligibility mask (1 = may be granted)
//   grant_o [2:0]  one-hot grant, zero when nothing is eligible
// -----------------------------------------------------------------------------
module rr_pick3
    import mem_arb_pkg::*;
(
    input  logic [2:0] valid_i,
    input  logic [1:0] ptr_i,
    input  logic [2:0] mask_i,
    output logic [2:0] grant_o
);

    logic [2:0] elig;

    assign elig = valid_i & mask_i;

    // The three search orders are written out explicitly; ptr_i == 3 never
    // occurs and falls back to the reset order.
    always_comb begin
        grant_o = 3'b000;
        case (ptr_i)
            REQ_FETCH: begin
                if (elig[1])      grant_o = 3'b010;
                else if (elig[2]) grant_o = 3'b100;
                else if (elig[0]) grant_o = 3'b001;
            end
            REQ_DUMP: begin
                if (elig[2])      grant_o = 3'b100;
                else if (elig[0]) grant_o = 3'b001;
                else if (elig[1]) grant_o = 3'b010;
            end
            default: begin
                if (elig[0])      grant_o = 3'b001;
                else if (elig[1]) grant_o = 3'b010;
                else if (elig[2]) grant_o = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-port 32x32 unified instruction/data memory between the
// load/store unit (0), instruction fetch (1) and the result-dump engine (2).
// Round-robin grant, combinational in the request cycle; the response for an
// accepted request appears exactly one cycle later with no stall path.
// A locked sequence lets the LSU keep the port across several accesses
// (atomic load-load-store-store swap) while fetch and dump wait.
//
// Optional build macro: MEM_ARB_STATS_EN adds per-requester saturating
// counters of accepted transactions (stat_grants) and wait cycles
// (stat_waits), 16 bits each, packed requester i at [i*16 +: 16].
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   req_valid/ready   per-requester handshake; ready is the one-hot grant
//   req_we/lock       per-requester write strobe / lock (only bit 0 used)
//   req_addr/wdata    packed per-requester address / write data
//   rsp_valid         one-hot response strobe, one cycle after accept
//   rsp_rdata         read data (zero for write acks), qualified by rsp_valid
//   mem_en/we/addr/wdata  access to the synchronous-read memory
//   mem_rdata         memory read data, valid the cycle after mem_en
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREQ   = NREQ_DEF      // fixed at 3
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ-1:0]        req_lock,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] stat_grants,
    output logic [NREQ*STAT_W-1:0] stat_waits
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e          state_q, state_d;
    req_id_t             rr_ptr_q, rr_ptr_d;

    logic                rsp_pend_q;
    req_id_t             rsp_id_q;
    logic                rsp_is_rd_q;

    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
    logic [2:0]          pick_mask;
    logic [2:0]          pick_grant;
    logic [NREQ-1:0]     grant;
    req_id_t             grant_id;
    logic                accept;

    // Lock bits of fetch and dump carry no meaning here.
    logic                unused_lock;
    assign unused_lock = ^req_lock[NREQ-1:1];

    // While locked, only the LSU may be picked; if it is idle the port idles.
    assign pick_mask = (state_q == LOCKED) ? 3'b001 : 3'b111;

    rr_pick3 u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .mask_i  (pick_mask),
        .grant_o (pick_grant)
    );

    // No access is started while reset is held, so memory is never written
    // by a request that the reset is about to discard.
    assign grant     = reset ? '0 : pick_grant;
    assign grant_id  = onehot_to_id(grant);
    assign accept    = |grant;
    assign req_ready = grant;

    // ------------------------------------------------------------------
    // Memory-side mux
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through it can infer a latch.
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        if (accept) begin
            mem_en    = 1'b1;
            mem_we    = req_we[grant_id];
            mem_addr  = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
            mem_wdata = req_wdata[int'(grant_id)*DATA_W +: DATA_W];
        end
    end

    // Address/data seen by the memory hold their last granted value while
    // the port is idle.
    always_ff @(posedge clk) begin
        // NOTE: these are pure datapath holding registers; they are not reset
        // because nothing downstream uses them while mem_en is low.
        if (accept) begin
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM and round-robin pointer
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (state_q == OPEN) begin
                rr_ptr_d = rr_next(grant_id);
                if (grant_id == REQ_LSU && req_lock[REQ_LSU]) begin
                    state_d = LOCKED;
                end
            end else if (!req_lock[REQ_LSU]) begin
                // Only the LSU can be accepted here; its unlocked access is
                // the last of the sequence and completes normally.
                state_d = OPEN;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (reset) begin
            state_q  <= OPEN;
            rr_ptr_q <= REQ_LSU;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Response path: one-cycle latency, no stall
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_pend_q  <= 1'b0;
            rsp_id_q    <= REQ_LSU;
            rsp_is_rd_q <= 1'b0;
        end else begin
            rsp_pend_q  <= accept;
            rsp_id_q    <= grant_id;
            rsp_is_rd_q <= accept && !mem_we;
        end
    end

    assign rsp_valid = rsp_pend_q ? id_to_onehot(rsp_id_q) : '0;
    // Write acks return zero data; memory data is forwarded only for reads.
    assign rsp_rdata = rsp_is_rd_q ? mem_rdata : '0;

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] grants_q [NREQ];
    logic [STAT_W-1:0] waits_q  [NREQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (reset) begin
                grants_q[i] <= '0;
                waits_q[i]  <= '0;
            end else begin
                if (grant[i] && grants_q[i] != '1) begin
                    grants_q[i] <= grants_q[i] + 1'b1;
                end
                if (req_valid[i] && !grant[i] && waits_q[i] != '1) begin
                    waits_q[i] <= waits_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        stat_waits  = '0;
        for (int i = 0; i < NREQ; i++) begin
            stat_grants[i*STAT_W +: STAT_W] = grants_q[i];
            stat_waits[i*STAT_W +: STAT_W]  = waits_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. A behavioural memory answers the
// arbiter's memory port; a reference model tracks the round-robin priority,
// the lock flag, the expected response and a shadow copy of memory contents.
// Directed sequences cover the documented scenarios, then randomized traffic
// (with occasional resets) runs against the same model.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    req_valid, req_ready, req_we, req_lock;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] req_wdata;
    logic [2:0]    rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [47:0]   stat_grants, stat_waits;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_waits  (stat_waits)
`endif
    );

    // Behavioural synchronous-read memory.
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus state
    // ------------------------------------------------------------------
    typedef struct {
        bit            v;
        bit            we;
        bit            lk;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    req_t rq [3];

    task automatic apply();
        for (int i = 0; i < 3; i++) begin
            req_valid[i]           = rq[i].v;
            req_we[i]              = rq[i].we;
            req_lock[i]            = rq[i].lk;
            req_addr[i*AW +: AW]   = rq[i].a;
            req_wdata[i*DW +: DW]  = rq[i].d;
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input bit lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        rq[i].v  = v;
        rq[i].we = we;
        rq[i].lk = lk;
        rq[i].a  = a;
        rq[i].d  = d;
        apply();
    endtask

    task automatic clear_all();
        for (int i = 0; i < 3; i++) rq[i] = '{v: 0, we: 0, lk: 0, a: '0, d: '0};
        apply();
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int            m_ptr;       // requester with top priority next
    bit            m_locked;
    logic [2:0]    m_rsp_v;
    logic [DW-1:0] m_rsp_d;
    logic [DW-1:0] ref_mem [32];
    bit            have_last = 0;
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;
    int            last_g;
`ifdef MEM_ARB_STATS_EN
    int            m_gr [3];
    int            m_wt [3];
`endif

    task automatic model_reset();
        m_ptr    = 0;
        m_locked = 0;
        m_rsp_v  = '0;
        m_rsp_d  = '0;
`ifdef MEM_ARB_STATS_EN
        for (int i = 0; i < 3; i++) begin m_gr[i] = 0; m_wt[i] = 0; end
`endif
    endtask

    // One clock cycle: entered just after a falling edge with inputs in rq,
    // checks everything visible this cycle, advances the model, and returns
    // at the next falling edge.
    task automatic step();
        int g;
        apply();
        #1;
        g = -1;
        if (!reset) begin
            if (m_locked) begin
                if (rq[0].v) g = 0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (g < 0 && rq[(m_ptr + k) % 3].v) g = (m_ptr + k) % 3;
                end
            end
        end
        check("req_ready", req_ready, (g >= 0) ? 3'(1 << g) : 3'b000);
        check("mem_en", mem_en, g >= 0);
        if (g >= 0) begin
            check("mem_we", mem_we, rq[g].we);
            check("mem_addr", mem_addr, rq[g].a);
            check("mem_wdata", mem_wdata, rq[g].d);
        end else begin
            check("mem_we_idle", mem_we, 1'b0);
            if (have_last) begin
                check("mem_addr_hold", mem_addr, last_a);
                check("mem_wdata_hold", mem_wdata, last_d);
            end
        end
        check("rsp_valid", rsp_valid, m_rsp_v);
        if (m_rsp_v != 0) check("rsp_rdata", rsp_rdata, m_rsp_d);
`ifdef MEM_ARB_STATS_EN
        for (int i = 0; i < 3; i++) begin
            check("stat_grants", stat_grants[i*16 +: 16], m_gr[i]);
            check("stat_waits", stat_waits[i*16 +: 16], m_wt[i]);
        end
`endif
        last_g = g;

        if (reset) begin
            model_reset();
        end else begin
`ifdef MEM_ARB_STATS_EN
            for (int i = 0; i < 3; i++) begin
                if (g == i && m_gr[i] < 65535) m_gr[i]++;
                if (rq[i].v && g != i && m_wt[i] < 65535) m_wt[i]++;
            end
`endif
            if (g >= 0) begin
                if (!m_locked) m_ptr = (g + 1) % 3;
                if (g == 0) m_locked = rq[0].lk;
                m_rsp_v = 3'(1 << g);
                m_rsp_d = rq[g].we ? '0 : ref_mem[rq[g].a];
                if (rq[g].we) ref_mem[rq[g].a] = rq[g].d;
                have_last = 1;
                last_a    = rq[g].a;
                last_d    = rq[g].d;
            end else begin
                m_rsp_v = '0;
                m_rsp_d = '0;
            end
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        clear_all();
        step();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0]     = 32'h4020000D;
        ref_mem[0] = 32'h4020000D;

        reset = 1'b1;
        clear_all();
        last_g = -1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Reset state.
        check("reset_rsp_valid", rsp_valid, 3'b000);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        step();

        // Single fetch read of address 0.
        set_req(1, 1, 0, 0, 5'd0, '0);
        #1 check("rd_ready", req_ready, 3'b010);
        step();
        clear_all();
        check("rd_rsp_valid", rsp_valid, 3'b010);
        check("rd_rsp_rdata", rsp_rdata, 32'h4020000D);
        step();

        // Contention from reset: grant order 0,1,2,0,1,2.
        pulse_reset();
        set_req(0, 1, 0, 0, 5'd1, '0);
        set_req(1, 1, 0, 0, 5'd2, '0);
        set_req(2, 1, 0, 0, 5'd3, '0);
        for (int k = 0; k < 6; k++) begin
            step();
            check("rr_order", last_g, k % 3);
        end
        clear_all();
        step();

        // Write ack, then read back.
        set_req(0, 1, 1, 0, 5'd21, 32'd10);
        #1;
        check("wr_mem_we", mem_we, 1'b1);
        check("wr_mem_addr", mem_addr, 5'd21);
        check("wr_mem_wdata", mem_wdata, 32'd10);
        step();
        clear_all();
        check("wr_ack_valid", rsp_valid, 3'b001);
        check("wr_ack_rdata", rsp_rdata, 32'h0);
        set_req(0, 1, 0, 0, 5'd21, '0);
        step();
        clear_all();
        check("wr_readback", rsp_rdata, 32'd10);
        step();

        // Locked swap with fetch and dump contending throughout.
        pulse_reset();
        set_req(1, 1, 0, 0, 5'd4, '0);
        set_req(2, 1, 0, 0, 5'd7, '0);
        set_req(0, 1, 0, 1, 5'd21, '0);
        step(); check("swap_g0", last_g, 0);
        set_req(0, 1, 0, 1, 5'd22, '0);
        step(); check("swap_g1", last_g, 0);
        set_req(0, 1, 1, 1, 5'd21, 32'hA5A5_0001);
        step(); check("swap_g2", last_g, 0);
        set_req(0, 1, 1, 0, 5'd22, 32'd10);
        step(); check("swap_g3", last_g, 0);
        set_req(0, 0, 0, 0, 5'd0, '0);
        step(); check("swap_after", last_g, 1);
        clear_all();
        step();

        // Locked bubble: LSU idle while locked, fetch must wait.
        set_req(0, 1, 0, 1, 5'd5, '0);
        step();
        set_req(0, 0, 0, 0, 5'd0, '0);
        set_req(1, 1, 0, 0, 5'd6, '0);
        for (int k = 0; k < 3; k++) begin
            #1 check("bubble_mem_en", mem_en, 1'b0);
            step();
        end
        set_req(0, 1, 0, 0, 5'd5, '0);
        step(); check("bubble_release", last_g, 0);
        clear_all();
        step();

        // Reset in the cycle after a locked read accept.
        set_req(0, 1, 0, 1, 5'd9, '0);
        step();
        check("rst_mid_rsp_seen", rsp_valid, 3'b001);
        pulse_reset();
        check("rst_mid_rsp_drop", rsp_valid, 3'b000);
        set_req(0, 1, 0, 0, 5'd1, '0);
        set_req(1, 1, 0, 0, 5'd2, '0);
        set_req(2, 1, 0, 0, 5'd3, '0);
        step(); check("rst_mid_first", last_g, 0);
        step(); check("rst_mid_open", last_g, 1);
        clear_all();
        step();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 3; i++) begin
                // A waiting request usually stays put (stable while !ready).
                if (rq[i].v && last_g != i && $urandom_range(0, 9) != 0) continue;
                rq[i].v  = $urandom_range(0, 1);
                rq[i].we = $urandom_range(0, 1);
                rq[i].lk = (i == 0) ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
                rq[i].a  = AW'($urandom_range(0, 31));
                rq[i].d  = $urandom;
            end
            step();
        end
        reset = 1'b0;
        clear_all();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
